seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-select seven-segment digits. Accepts a packed hex value through a valid/ready handshake and double-buffers it so a new value never tears mid-frame. Each refresh tick it selects one digit and drives that digit's segment pattern, refreshing all digits cyclically. Sits between the CPU's memory-mapped display register and the board's segment/select pins.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller:
// segment pattern table, output width and the digit one-hot helper.
package seg7_pkg;

  localparam int SEG_W      = 8;
  localparam int MAX_DIGITS = 16;

  typedef logic [3:0] nibble_t;

  // Active-low 7-bit patterns, bit order {g,f,a,b,e,d,c} as wired on the board.
  // Entry 15 first (F) down to entry 0 (0).
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h0B, 7'h09, 7'h30, 7'h49, 7'h18, 7'h02, 7'h04, 7'h00,
    7'h66, 7'h08, 7'h0C, 7'h16, 7'h24, 7'h21, 7'h76, 7'h40
  };

  // Segment word for a '0' with the decimal point off.
  localparam logic [SEG_W-1:0] SEG_ZERO = 8'h7E;

  // One-hot select for a digit index; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] digit_onehot(input logic [3:0] idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble + decimal point to segment word converter.
// seg[7:1] are active-high segments, seg[0] is the decimal point.
module seg7_decode
  import seg7_pkg::*;
(
  input  nibble_t          nibble,
  input  logic             dp,
  output logic [SEG_W-1:0] seg
);

  assign seg = {~SEG_PAT[nibble], dp};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
// A loaded value is held in a pending buffer and only copied to the display
// buffer on the tick that wraps the scan back to digit 0, so a frame never
// mixes old and new digits.
// Optional feature: define SEG7_LZ_BLANK_EN to blank leading-zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 50000
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [4*NUM_DIGITS-1:0] iVALUE,
  input  logic                    iLOAD,
  output logic                    oREADY,
  input  logic [NUM_DIGITS-1:0]   iDP,
  output logic [NUM_DIGITS-1:0]   oDIG_SEL,
  output logic [SEG_W-1:0]        oSEG,
  output logic                    oFRAME
);

  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc_reg, presc_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [VW-1:0]         pend_reg, pend_next;
  logic [VW-1:0]         disp_reg, disp_next;
  logic                  pending_reg, pending_next;
  logic [NUM_DIGITS-1:0] dig_sel_reg, dig_sel_next;
  logic [SEG_W-1:0]      seg_reg, seg_next, dec_seg;
  logic                  frame_reg;

  logic                  tick, wrap, load_acc, commit;
  logic                  blank;
  nibble_t               nib [NUM_DIGITS];

  assign tick     = (presc_reg == PW'(DIV - 1));
  assign wrap     = tick && (idx_reg == IW'(NUM_DIGITS - 1));
  assign load_acc = iLOAD && !pending_reg;
  assign commit   = wrap && pending_reg;

  // Next-state for prescaler, scan index, buffers and the select output.
  always_comb begin
    presc_next = tick ? '0 : presc_reg + 1'b1;
    idx_next   = idx_reg;
    if (tick) begin
      idx_next = wrap ? '0 : idx_reg + 1'b1;
    end
    pend_next    = load_acc ? iVALUE : pend_reg;
    disp_next    = commit ? pend_reg : disp_reg;
    pending_next = pending_reg;
    if (load_acc) begin
      pending_next = 1'b1;
    end else if (commit) begin
      pending_next = 1'b0;
    end
    dig_sel_next = NUM_DIGITS'(digit_onehot(4'(idx_next)));
  end

  // Split the post-commit display value into per-digit nibbles.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = disp_next[4*gi +: 4];
    end
  endgenerate

  // Single decoder on the digit that becomes active at the next edge.
  seg7_decode u_decode (
    .nibble (nib[idx_next]),
    .dp     (iDP[idx_next]),
    .seg    (dec_seg)
  );

`ifdef SEG7_LZ_BLANK_EN
  // upper_zero[k] is set when nibbles k..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS:0] upper_zero;
  assign upper_zero[NUM_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      assign upper_zero[gi] = (nib[gi] == 4'h0) && upper_zero[gi+1];
    end
  endgenerate
  // Digit 0 always shows, so an all-zero value still reads "0".
  assign blank = (idx_next != '0) && upper_zero[idx_next];
`else
  assign blank = 1'b0;
`endif

  // Blanked digits keep the live decimal point.
  always_comb begin
    seg_next = dec_seg;
    if (blank) begin
      seg_next = {{(SEG_W-1){1'b0}}, dec_seg[0]};
    end
  end

  // State and registered outputs; reset discards any pending load.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      presc_reg   <= '0;
      idx_reg     <= '0;
      pend_reg    <= '0;
      disp_reg    <= '0;
      pending_reg <= 1'b0;
      dig_sel_reg <= NUM_DIGITS'(1);
      seg_reg     <= SEG_ZERO;
      frame_reg   <= 1'b0;
    end else begin
      presc_reg   <= presc_next;
      idx_reg     <= idx_next;
      pend_reg    <= pend_next;
      disp_reg    <= disp_next;
      pending_reg <= pending_next;
      dig_sel_reg <= dig_sel_next;
      seg_reg     <= seg_next;
      frame_reg   <= wrap;
    end
  end

  assign oREADY   = !pending_reg;
  assign oDIG_SEL = dig_sel_reg;
  assign oSEG     = seg_reg;
  assign oFRAME   = frame_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with 4 digits and 4 cycles per digit.
// Expected digit slots are queued per frame; a monitor pops one entry each
// time a new digit is selected and checks it for every cycle of that slot.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int DV = 4;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [7:0] Z = 8'h00;
`else
  localparam logic [7:0] Z = 8'h7E;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp = '0;
  logic        ready;
  logic [3:0]  dig_sel;
  logic [7:0]  seg;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DV)) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .iVALUE   (value),
    .iLOAD    (load),
    .oREADY   (ready),
    .iDP      (dp),
    .oDIG_SEL (dig_sel),
    .oSEG     (seg),
    .oFRAME   (frame)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         mon_en = 1'b1;
  logic [3:0] mon_prev_sel = '0;
  int         mon_slot_len = 0;
  bit         mon_have_cur = 1'b0;
  exp_t       mon_cur = '0;
  int         n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    exp_q.push_back({4'b0001, s0});
    exp_q.push_back({4'b0010, s1});
    exp_q.push_back({4'b0100, s2});
    exp_q.push_back({4'b1000, s3});
  endtask

  task automatic wait_frame(output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step(1);
      cycles++;
      if (frame) seen = 1'b1;
    end
    chk("frame_seen", seen, 1);
  endtask

  task automatic do_load(input logic [15:0] v);
    $display("load value=%h ready=%0b", v, ready);
    value = v;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          mon_prev_sel = '0;
          mon_slot_len = 0;
          mon_have_cur = 1'b0;
        end else if (mon_en) begin
          if (dig_sel != mon_prev_sel) begin
            if (mon_prev_sel != '0) chk("slot_len", mon_slot_len, DV);
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              mon_cur      = exp_q.pop_front();
              mon_have_cur = 1'b1;
            end else begin
              mon_have_cur = 1'b0;
            end
            mon_slot_len = 0;
            mon_prev_sel = dig_sel;
          end
          mon_slot_len++;
          if (mon_have_cur) begin
            chk("slot_sel", dig_sel, mon_cur.sel);
            chk("slot_seg", seg, mon_cur.seg);
          end
        end
      end
    join_none

    // Reset state
    step(3);
    chk("reset_sel", dig_sel, 4'b0001);
    chk("reset_seg", seg, 8'h7E);
    chk("reset_ready", ready, 1);
    chk("reset_frame", frame, 0);
    push_frame(8'h7E, Z, Z, Z);
    rst_n = 1'b1;
    chk("release_sel", dig_sel, 4'b0001);
    step(4);
    chk("sel_after_div", dig_sel, 4'b0010);

    // Frame timing
    wait_frame(n);
    chk("first_frame_cycles", n, 12);
    push_frame(8'h7E, Z, Z, Z);
    step(1);
    chk("frame_pulse_width", frame, 0);
    wait_frame(n);
    chk("frame_period", n, 15);
    push_frame(8'h7E, Z, Z, Z);

    // Mid-frame load, then an ignored load while pending
    step(4);
    do_load(16'h1850);
    chk("ready_fall", ready, 0);
    step(2);
    do_load(16'hFFFF);
    chk("ready_held", ready, 0);
    wait_frame(n);
    chk("ready_rise", ready, 1);
    push_frame(8'h7E, 8'hE6, 8'hFE, 8'h12);
    wait_frame(n);
    push_frame(8'h7E, 8'hE6, 8'hFE, 8'h12);

    // Leading zeros
    step(3);
    do_load(16'h0050);
    chk("ready_fall_0050", ready, 0);
    wait_frame(n);
    chk("ready_rise_0050", ready, 1);
    push_frame(8'h7E, 8'hE6, Z, Z);
    step(3);
    do_load(16'h0000);
    chk("ready_fall_0000", ready, 0);
    wait_frame(n);
    push_frame(8'h7E, Z, Z | 8'h01, Z);
    dp = 4'b0100;

    // Decimal point on digit 2 only
    wait_frame(n);
    push_frame(8'h7E, Z, Z | 8'h01, Z);

    // Reset mid-frame with a load pending
    step(4);
    do_load(16'h1850);
    chk("ready_fall_prerst", ready, 0);
    step(4);
    rst_n = 1'b0;
    dp    = '0;
    #1;
    chk("midrst_sel", dig_sel, 4'b0001);
    chk("midrst_seg", seg, 8'h7E);
    chk("midrst_ready", ready, 1);
    chk("midrst_frame", frame, 0);
    exp_q.delete();
    step(2);
    push_frame(8'h7E, Z, Z, Z);
    rst_n = 1'b1;
    wait_frame(n);
    chk("frame_after_rst", n, 16);
    push_frame(8'h7E, Z, Z, Z);
    wait_frame(n);
    mon_en = 1'b0;
    chk("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
